gige_tx_sched: RTL and testbench

- Shares the two-bank (ping-pong) transmit frame buffer between NREQ frame producers and sequences the gigabit egress engine.
- Grants bank write access round-robin and tracks per-bank full/free state.
- Issues start_send pulses to the egress engine in strict bank order and frees each bank when the engine's busy falls.
- Sits between the producer logic and the egress engine, in the TFCLK domain.

---
 rtl/gige_pkg.sv | 16 +
 rtl/gige_rr_arb.sv | 38 +++
 rtl/gige_tx_sched.sv | 177 +++++++++++++++++
 tb/tb_gige_tx_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gige_pkg.sv
// Shared constants for the gigabit transmit scheduler:
// send-state encoding, bank count and default timing values.
package gige_pkg;

  localparam int BANKS       = 2;
  localparam int HOLD_DEF    = 4;
  localparam int GAP_DEF     = 4;
  localparam int BUSY_TO_DEF = 1024;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PULSE  = 3'd1;
  localparam logic [2:0] S_WAITHI = 3'd2;
  localparam logic [2:0] S_WAITLO = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

endpackage

// File: rtl/gige_rr_arb.sv
// Combinational round-robin winner select over NREQ requesters.
// Ports: req_i, ptr_i (search start) -> valid_o, idx_o, onehot_o.
module gige_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic                    valid_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic [NREQ-1:0]         onehot_o
);

  localparam int PW = $clog2(NREQ);

  int            j;
  logic [PW-1:0] jj;

  // Scan offsets from highest to lowest so the requester
  // closest to ptr_i is the last one written and wins.
  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    j        = 0;
    jj       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      jj = PW'(j);
      if (req_i[jj]) begin
        valid_o = 1'b1;
        idx_o   = jj;
      end
    end
    if (valid_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/gige_tx_sched.sv
// Ping-pong TX buffer arbiter and egress start sequencer.
// Ports: TFCLK, RST, enable, req, wr_done, wr_abort, busy ->
//   grant, wr_bank, start_send, bank_full, tx_count, err_timeout.
module gige_tx_sched
  import gige_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int HOLD    = HOLD_DEF,
  parameter int GAP     = GAP_DEF,
  parameter int BUSY_TO = BUSY_TO_DEF
) (
  input  logic             TFCLK,
  input  logic             RST,
  input  logic             enable,
  input  logic [NREQ-1:0]  req,
  input  logic             wr_done,
  input  logic             wr_abort,
  input  logic             busy,
  output logic [NREQ-1:0]  grant,
  output logic             wr_bank,
  output logic             start_send,
  output logic [BANKS-1:0] bank_full,
  output logic [15:0]      tx_count,
  output logic             err_timeout
);

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0]  grant_q, grant_d;
  logic             wr_bank_q, wr_bank_d;
  logic             fill_q, fill_d;
  logic             send_q, send_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [BANKS-1:0] full_q, full_d;
  logic [2:0]       st_q, st_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [15:0]      tx_q, tx_d;
  logic             err_q, err_d;
  logic             set_full;
  logic             clr_full;

  logic             arb_valid;
  logic [PW-1:0]    arb_idx;
  logic [NREQ-1:0]  arb_onehot;

  gige_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i    (req),
    .ptr_i    (rr_q),
    .valid_o  (arb_valid),
    .idx_o    (arb_idx),
    .onehot_o (arb_onehot)
  );

  // Write side: a held grant only reacts to done/abort;
  // a new grant needs the current fill bank to be free.
  always_comb begin
    grant_d   = grant_q;
    wr_bank_d = wr_bank_q;
    fill_d    = fill_q;
    rr_d      = rr_q;
    set_full  = 1'b0;
    if (|grant_q) begin
      if (wr_done) begin
        set_full = 1'b1;
        fill_d   = ~fill_q;
        grant_d  = '0;
      end else if (wr_abort) begin
        grant_d = '0;
      end
    end else if (enable && !full_q[fill_q] && arb_valid) begin
      grant_d   = arb_onehot;
      wr_bank_d = fill_q;
      rr_d      = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    send_d   = send_q;
    tx_d     = tx_q;
    err_d    = err_q;
    clr_full = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (enable && full_q[send_q]) begin
          st_d  = S_PULSE;
          cnt_d = '0;
        end
      end
      S_PULSE: begin
        if (cnt_q == 32'(HOLD - 1)) begin
          st_d  = S_WAITHI;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAITHI: begin
        if (busy) begin
          st_d = S_WAITLO;
        end else if (cnt_q == 32'(BUSY_TO - 1)) begin
          // Bank stays full so the frame is pulsed again.
          err_d = 1'b1;
          st_d  = S_GAP;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAITLO: begin
        if (!busy) begin
          clr_full = 1'b1;
          send_d   = ~send_q;
          tx_d     = tx_q + 16'd1;
          st_d     = S_GAP;
          cnt_d    = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == 32'(GAP - 1)) begin
          st_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        st_d  = S_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // Fill and send sides touch different banks whenever
  // both fire in the same cycle, so both updates apply.
  always_comb begin
    full_d = full_q;
    if (clr_full) full_d[send_q] = 1'b0;
    if (set_full) full_d[fill_q] = 1'b1;
  end

  always_ff @(posedge TFCLK or posedge RST) begin
    if (RST) begin
      grant_q   <= '0;
      wr_bank_q <= 1'b0;
      fill_q    <= 1'b0;
      send_q    <= 1'b0;
      rr_q      <= '0;
      full_q    <= '0;
      st_q      <= S_IDLE;
      cnt_q     <= '0;
      tx_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      wr_bank_q <= wr_bank_d;
      fill_q    <= fill_d;
      send_q    <= send_d;
      rr_q      <= rr_d;
      full_q    <= full_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      err_q     <= err_d;
    end
  end

  assign grant       = grant_q;
  assign wr_bank     = wr_bank_q;
  assign start_send  = (st_q == S_PULSE);
  assign bank_full   = full_q;
  assign tx_count    = tx_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_gige_tx_sched.sv
// Directed bench for gige_tx_sched with a simple egress
// busy model (rise N cycles after start_send, hold L cycles).
module tb_gige_tx_sched;

  logic        TFCLK;
  logic        RST;
  logic        enable;
  logic [3:0]  req;
  logic        wr_done;
  logic        wr_abort;
  logic        busy;
  logic [3:0]  grant;
  logic        wr_bank;
  logic        start_send;
  logic [1:0]  bank_full;
  logic [15:0] tx_count;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  // busy model: 0 = reacts to start_send, 1 = high, 2 = low
  int   bmode;
  int   blen;
  int   bt;
  logic bact;
  logic ss_prev;

  gige_tx_sched #(
    .NREQ    (4),
    .HOLD    (4),
    .GAP     (4),
    .BUSY_TO (16)
  ) dut (
    .TFCLK       (TFCLK),
    .RST         (RST),
    .enable      (enable),
    .req         (req),
    .wr_done     (wr_done),
    .wr_abort    (wr_abort),
    .busy        (busy),
    .grant       (grant),
    .wr_bank     (wr_bank),
    .start_send  (start_send),
    .bank_full   (bank_full),
    .tx_count    (tx_count),
    .err_timeout (err_timeout)
  );

  initial TFCLK = 1'b0;
  always #5 TFCLK = ~TFCLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge TFCLK);
    #1;
    if (bmode == 0) begin
      if (start_send && !ss_prev) begin
        bact = 1'b1;
        bt   = 0;
      end else if (bact) begin
        bt++;
      end
      busy = bact && (bt >= 5) && (bt < 5 + blen);
      if (bact && bt >= 5 + blen) bact = 1'b0;
    end else begin
      busy = (bmode == 1);
    end
    ss_prev = start_send;
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    enable   = 1'b0;
    req      = 4'b0000;
    wr_done  = 1'b0;
    wr_abort = 1'b0;
    bmode    = 2;
    blen     = 10;
    busy     = 1'b0;
    bact     = 1'b0;
    bt       = 0;
    ss_prev  = 1'b0;
    step();
    step();
    RST = 1'b0;
    step();
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (grant == 4'b0000 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_wait"}, 32'(grant != 4'b0000), 32'd1);
  endtask

  task automatic pulse_done();
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
  endtask

  initial begin
    int hi;
    int n;
    logic seen;

    // Reset values
    do_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_bank", 32'(wr_bank), 32'h0);
    chk("rst_ss", 32'(start_send), 32'h0);
    chk("rst_full", 32'(bank_full), 32'h0);
    chk("rst_tx", 32'(tx_count), 32'h0);
    chk("rst_err", 32'(err_timeout), 32'h0);

    // Single producer, one full frame
    do_reset();
    bmode  = 0;
    blen   = 60;
    enable = 1'b1;
    req    = 4'b0001;
    wait_grant("t1");
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_bank", 32'(wr_bank), 32'h0);
    req = 4'b0000;
    pulse_done();
    chk("t1_gclr", 32'(grant), 32'h0);
    chk("t1_full1", 32'(bank_full), 32'h1);
    hi = 0;
    n  = 0;
    while (tx_count != 16'd1 && n < 300) begin
      step();
      if (start_send) hi++;
      n++;
    end
    chk("t1_hold", 32'(hi), 32'd4);
    chk("t1_full0", 32'(bank_full), 32'h0);
    chk("t1_tx", 32'(tx_count), 32'd1);
    chk("t1_err", 32'(err_timeout), 32'h0);

    // Four producers, round-robin order
    do_reset();
    bmode  = 0;
    blen   = 10;
    enable = 1'b1;
    req    = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant($sformatf("t2_%0d", k));
      chk($sformatf("t2_grant%0d", k), 32'(grant), 32'(1 << (k % 4)));
      chk($sformatf("t2_bank%0d", k), 32'(wr_bank), 32'(k % 2));
      step();
      pulse_done();
      chk($sformatf("t2_gclr%0d", k), 32'(grant), 32'h0);
    end

    // Both banks full with busy stuck high
    do_reset();
    bmode  = 1;
    busy   = 1'b1;
    enable = 1'b1;
    req    = 4'b0001;
    wait_grant("t3a");
    chk("t3_bank0", 32'(wr_bank), 32'h0);
    pulse_done();
    wait_grant("t3b");
    chk("t3_bank1", 32'(wr_bank), 32'h1);
    pulse_done();
    chk("t3_full", 32'(bank_full), 32'h3);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (grant != 4'b0000) seen = 1'b1;
    end
    chk("t3_blocked", 32'(seen), 32'h0);
    bmode = 2;
    busy  = 1'b0;
    step();
    chk("t3_free0", 32'(bank_full), 32'h2);
    step();
    chk("t3_regrant", 32'(grant), 32'h1);
    chk("t3_rebank", 32'(wr_bank), 32'h0);

    // Busy never rises: timeout and retry
    do_reset();
    bmode  = 2;
    enable = 1'b1;
    req    = 4'b0001;
    wait_grant("t4");
    req = 4'b0000;
    pulse_done();
    n = 0;
    while (!start_send && n < 20) begin
      step();
      n++;
    end
    chk("t4_pulse", 32'(start_send), 32'h1);
    n = 0;
    while (!err_timeout && n < 100) begin
      step();
      n++;
    end
    chk("t4_err", 32'(err_timeout), 32'h1);
    chk("t4_tocyc", 32'(n), 32'd20);
    n = 0;
    while (!start_send && n < 20) begin
      step();
      n++;
    end
    chk("t4_retry", 32'(n >= 4 && n <= 6), 32'h1);
    chk("t4_full", 32'(bank_full), 32'h1);
    chk("t4_tx", 32'(tx_count), 32'h0);

    // Abort, stray done, and done+abort together
    do_reset();
    bmode  = 2;
    enable = 1'b1;
    req    = 4'b0001;
    wait_grant("t5a");
    req      = 4'b0000;
    wr_abort = 1'b1;
    step();
    wr_abort = 1'b0;
    chk("t5_abgclr", 32'(grant), 32'h0);
    chk("t5_abfull", 32'(bank_full), 32'h0);
    pulse_done();
    chk("t5_strayfull", 32'(bank_full), 32'h0);
    req = 4'b0001;
    wait_grant("t5b");
    chk("t5_nofill", 32'(wr_bank), 32'h0);
    wr_done  = 1'b1;
    wr_abort = 1'b1;
    step();
    wr_done  = 1'b0;
    wr_abort = 1'b0;
    chk("t5_bothfull", 32'(bank_full), 32'h1);
    wait_grant("t5c");
    chk("t5_fill1", 32'(wr_bank), 32'h1);

    // Asynchronous reset while the engine is busy
    do_reset();
    bmode  = 1;
    busy   = 1'b1;
    enable = 1'b1;
    req    = 4'b0001;
    wait_grant("t6a");
    pulse_done();
    wait_grant("t6b");
    for (int i = 0; i < 8; i++) step();
    chk("t6_pre", 32'(bank_full), 32'h1);
    #1;
    RST = 1'b1;
    #1;
    chk("t6_grant", 32'(grant), 32'h0);
    chk("t6_bank", 32'(wr_bank), 32'h0);
    chk("t6_ss", 32'(start_send), 32'h0);
    chk("t6_full", 32'(bank_full), 32'h0);
    chk("t6_tx", 32'(tx_count), 32'h0);
    chk("t6_err", 32'(err_timeout), 32'h0);
    step();
    RST   = 1'b0;
    bmode = 0;
    step();
    wait_grant("t6c");
    chk("t6_bank0", 32'(wr_bank), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
